ami_w_arb: RTL and testbench

Write-channel arbiter that shares one AXI write master port (AW/W/B) between NREQ local requesters, e.g. several DMA engines feeding a single ami_w instance.
- Round-robin arbitration on AW.
- W beats are steered in AW-grant order through an order FIFO.
- Global outstanding-transaction limit.
- B responses are routed back by an index encoded in the top ID bits.
- Single clock domain (ACLK); sits between requesters and the ami_w user port.

---
 rtl/ami_pkg.sv | 18 +
 rtl/ami_sfifo.sv | 51 +++++
 rtl/ami_w_arb.sv | 193 +++++++++++++++++++
 tb/tb_ami_w_arb.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ami_pkg.sv
// Shared AXI encodings and arbiter state type for the ami_* write-path blocks.
package ami_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } aw_state_e;

endpackage

// File: rtl/ami_sfifo.sv
// Single-clock FIFO with registered pointers; push and pop may occur together.
module ami_sfifo #(
  parameter int DW    = 2,
  parameter int DEPTH = 4
) (
  input  logic          ACLK,
  input  logic          ARESETn,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ami_w_arb.sv
// Shares one AXI write master (AW/W/B) between NREQ requesters: round-robin AW,
// W steered in AW-grant order, global outstanding limit, B routed by top ID bits.
module ami_w_arb
  import ami_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int AXI_DW  = 128,
  parameter int AXI_AW  = 32,
  parameter int AXI_IW  = 8,
  parameter int AXI_LW  = 8,
  parameter int AXI_SW  = 3,
  parameter int ORD_D   = 4,
  parameter int OST_MAX = 8,
  localparam int REQ_W      = $clog2(NREQ),
  localparam int AXI_WSTRBW = AXI_DW / 8
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic [NREQ*AXI_IW-1:0]     s_awid,
  input  logic [NREQ*AXI_AW-1:0]     s_awaddr,
  input  logic [NREQ*AXI_LW-1:0]     s_awlen,
  input  logic [NREQ*AXI_SW-1:0]     s_awsize,
  input  logic [NREQ*2-1:0]          s_awburst,
  input  logic [NREQ-1:0]            s_awvalid,
  output logic [NREQ-1:0]            s_awready,
  input  logic [NREQ*AXI_DW-1:0]     s_wdata,
  input  logic [NREQ*AXI_WSTRBW-1:0] s_wstrb,
  input  logic [NREQ-1:0]            s_wlast,
  input  logic [NREQ-1:0]            s_wvalid,
  output logic [NREQ-1:0]            s_wready,
  output logic [AXI_IW-1:0]          s_bid,
  output logic [1:0]                 s_bresp,
  output logic [NREQ-1:0]            s_bvalid,
  input  logic [NREQ-1:0]            s_bready,
  output logic [AXI_IW-1:0]          m_awid,
  output logic [AXI_AW-1:0]          m_awaddr,
  output logic [AXI_LW-1:0]          m_awlen,
  output logic [AXI_SW-1:0]          m_awsize,
  output logic [1:0]                 m_awburst,
  output logic                       m_awvalid,
  input  logic                       m_awready,
  output logic [AXI_DW-1:0]          m_wdata,
  output logic [AXI_WSTRBW-1:0]      m_wstrb,
  output logic                       m_wlast,
  output logic                       m_wvalid,
  input  logic                       m_wready,
  input  logic [AXI_IW-1:0]          m_bid,
  input  logic [1:0]                 m_bresp,
  input  logic                       m_bvalid,
  output logic                       m_bready,
  output logic                       err_bid
);

  localparam int                OST_W    = $clog2(OST_MAX + 1);
  localparam logic [OST_W-1:0]  OST_LIM  = OST_W'(OST_MAX);
  localparam logic [REQ_W-1:0]  LAST_REQ = REQ_W'(NREQ - 1);
  localparam logic [REQ_W:0]    NREQ_EXT = (REQ_W + 1)'(NREQ);

  aw_state_e         state_q, state_d;
  logic [REQ_W-1:0]  grant_q, grant_d;
  logic [REQ_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [OST_W-1:0]  ost_cnt_q, ost_cnt_d;
  logic              err_bid_q, err_bid_d;

  logic              ord_push, ord_pop, ord_full, ord_empty;
  logic [REQ_W-1:0]  w_sel;
  logic [REQ_W-1:0]  b_idx;
  logic              b_idx_ok;
  logic              b_hs;
  logic              awid_unused;

  // First requesting index at or above ptr, wrapping past NREQ-1.
  function automatic logic [REQ_W-1:0] rr_pick(input logic [NREQ-1:0]  req,
                                               input logic [REQ_W-1:0] ptr);
    logic [REQ_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        pick  = REQ_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    m_awvalid = 1'b0;
    s_awready = '0;
    ord_push  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|s_awvalid && !ord_full && (ost_cnt_q < OST_LIM)) begin
          grant_d = rr_pick(s_awvalid, rr_ptr_q);
          state_d = BUSY;
        end
      end
      BUSY: begin
        m_awvalid          = 1'b1;
        s_awready[grant_q] = m_awready;
        if (m_awready) begin
          ord_push = 1'b1;
          rr_ptr_d = (grant_q == LAST_REQ) ? '0 : grant_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The requester index replaces the top ID bits so B can find its way back.
  assign m_awid      = {grant_q, s_awid[grant_q*AXI_IW +: (AXI_IW - REQ_W)]};
  assign m_awaddr    = s_awaddr[grant_q*AXI_AW +: AXI_AW];
  assign m_awlen     = s_awlen[grant_q*AXI_LW +: AXI_LW];
  assign m_awsize    = s_awsize[grant_q*AXI_SW +: AXI_SW];
  assign m_awburst   = s_awburst[grant_q*2 +: 2];
  assign awid_unused = ^s_awid;

  ami_sfifo #(
    .DW    (REQ_W),
    .DEPTH (ORD_D)
  ) u_ord_fifo (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .push_i  (ord_push),
    .wdata_i (grant_q),
    .pop_i   (ord_pop),
    .rdata_o (w_sel),
    .full_o  (ord_full),
    .empty_o (ord_empty)
  );

  assign m_wvalid = ~ord_empty & s_wvalid[w_sel];
  assign m_wdata  = s_wdata[w_sel*AXI_DW +: AXI_DW];
  assign m_wstrb  = s_wstrb[w_sel*AXI_WSTRBW +: AXI_WSTRBW];
  assign m_wlast  = s_wlast[w_sel];
  assign ord_pop  = m_wvalid & m_wready & m_wlast;

  always_comb begin
    s_wready        = '0;
    s_wready[w_sel] = m_wready & ~ord_empty;
  end

  assign b_idx    = m_bid[AXI_IW-1 -: REQ_W];
  assign b_idx_ok = ({1'b0, b_idx} < NREQ_EXT);
  assign s_bid    = {{REQ_W{1'b0}}, m_bid[AXI_IW-REQ_W-1:0]};
  assign s_bresp  = m_bresp;
  assign b_hs     = m_bvalid & m_bready;
  assign err_bid  = err_bid_q;

  // Responses carrying an index with no requester are swallowed and flagged.
  always_comb begin
    s_bvalid  = '0;
    m_bready  = 1'b1;
    err_bid_d = err_bid_q | (m_bvalid & ~b_idx_ok);
    if (b_idx_ok) begin
      s_bvalid[b_idx] = m_bvalid;
      m_bready        = s_bready[b_idx];
    end
  end

  always_comb begin
    ost_cnt_d = ost_cnt_q;
    case ({ord_push, b_hs})
      2'b10:   ost_cnt_d = ost_cnt_q + 1'b1;
      2'b01:   ost_cnt_d = ost_cnt_q - 1'b1;
      default: ost_cnt_d = ost_cnt_q;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      ost_cnt_q <= '0;
      err_bid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      ost_cnt_q <= ost_cnt_d;
      err_bid_q <= err_bid_d;
    end
  end

endmodule

// File: tb/tb_ami_w_arb.sv
// Self-checking bench for ami_w_arb: B-routing vector table plus scoreboarded AW/W sequences.
module tb_ami_w_arb;
  import ami_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;

  logic                 ACLK;
  logic                 ARESETn;
  logic [NREQ*8-1:0]    sAwid;
  logic [NREQ*32-1:0]   sAwaddr;
  logic [NREQ*8-1:0]    sAwlen;
  logic [NREQ*3-1:0]    sAwsize;
  logic [NREQ*2-1:0]    sAwburst;
  logic [NREQ-1:0]      sAwvalid;
  logic [NREQ-1:0]      sAwready;
  logic [NREQ*DW-1:0]   sWdata;
  logic [NREQ*SW-1:0]   sWstrb;
  logic [NREQ-1:0]      sWlast;
  logic [NREQ-1:0]      sWvalid;
  logic [NREQ-1:0]      sWready;
  logic [7:0]           sBid;
  logic [1:0]           sBresp;
  logic [NREQ-1:0]      sBvalid;
  logic [NREQ-1:0]      sBready;
  logic [7:0]           mAwid;
  logic [31:0]          mAwaddr;
  logic [7:0]           mAwlen;
  logic [2:0]           mAwsize;
  logic [1:0]           mAwburst;
  logic                 mAwvalid;
  logic                 mAwready;
  logic [DW-1:0]        mWdata;
  logic [SW-1:0]        mWstrb;
  logic                 mWlast;
  logic                 mWvalid;
  logic                 mWready;
  logic [7:0]           mBid;
  logic [1:0]           mBresp;
  logic                 mBvalid;
  logic                 mBready;
  logic                 errBid;

  // Three-requester instance used only for out-of-range B index handling.
  logic [2:0]  sAwready3, sWready3, sBvalid3;
  logic [7:0]  sBid3, mAwid3, mBid3;
  logic [1:0]  sBresp3, mAwburst3;
  logic [31:0] mAwaddr3;
  logic [7:0]  mAwlen3;
  logic [2:0]  mAwsize3;
  logic        mAwvalid3, mWlast3, mWvalid3, mBvalid3, mBready3, errBid3;
  logic [DW-1:0] mWdata3;
  logic [SW-1:0] mWstrb3;

  int nChecks = 0;
  int nFail   = 0;
  int wRemain [NREQ];
  int guardReq   = -1;
  int guardUntil = 0;
  bit autoB      = 1'b0;

  logic [47:0] expAw [$];
  logic [36:0] expW  [$];
  logic [7:0]  pendB [$];

  typedef struct {
    logic [7:0] bid;
    logic [1:0] resp;
    logic       bvalid;
    logic [3:0] bready;
    logic [3:0] expBvalid;
    logic [7:0] expBid;
    logic       expMBready;
  } bvec_t;

  bvec_t vecs [5];

  ami_w_arb #(
    .NREQ(NREQ), .AXI_DW(DW), .AXI_AW(32), .AXI_IW(8), .AXI_LW(8), .AXI_SW(3),
    .ORD_D(4), .OST_MAX(2)
  ) u_dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_awid(sAwid), .s_awaddr(sAwaddr), .s_awlen(sAwlen), .s_awsize(sAwsize),
    .s_awburst(sAwburst), .s_awvalid(sAwvalid), .s_awready(sAwready),
    .s_wdata(sWdata), .s_wstrb(sWstrb), .s_wlast(sWlast), .s_wvalid(sWvalid),
    .s_wready(sWready), .s_bid(sBid), .s_bresp(sBresp), .s_bvalid(sBvalid),
    .s_bready(sBready), .m_awid(mAwid), .m_awaddr(mAwaddr), .m_awlen(mAwlen),
    .m_awsize(mAwsize), .m_awburst(mAwburst), .m_awvalid(mAwvalid),
    .m_awready(mAwready), .m_wdata(mWdata), .m_wstrb(mWstrb), .m_wlast(mWlast),
    .m_wvalid(mWvalid), .m_wready(mWready), .m_bid(mBid), .m_bresp(mBresp),
    .m_bvalid(mBvalid), .m_bready(mBready), .err_bid(errBid)
  );

  ami_w_arb #(
    .NREQ(3), .AXI_DW(DW), .AXI_AW(32), .AXI_IW(8), .AXI_LW(8), .AXI_SW(3),
    .ORD_D(4), .OST_MAX(2)
  ) u_dut3 (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_awid('0), .s_awaddr('0), .s_awlen('0), .s_awsize('0),
    .s_awburst('0), .s_awvalid('0), .s_awready(sAwready3),
    .s_wdata('0), .s_wstrb('0), .s_wlast('0), .s_wvalid('0),
    .s_wready(sWready3), .s_bid(sBid3), .s_bresp(sBresp3), .s_bvalid(sBvalid3),
    .s_bready(3'b111), .m_awid(mAwid3), .m_awaddr(mAwaddr3), .m_awlen(mAwlen3),
    .m_awsize(mAwsize3), .m_awburst(mAwburst3), .m_awvalid(mAwvalid3),
    .m_awready(1'b0), .m_wdata(mWdata3), .m_wstrb(mWstrb3), .m_wlast(mWlast3),
    .m_wvalid(mWvalid3), .m_wready(1'b0), .m_bid(mBid3), .m_bresp(2'b00),
    .m_bvalid(mBvalid3), .m_bready(mBready3), .err_bid(errBid3)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every master-side handshake must match the oldest expectation.
  always @(negedge ACLK) begin
    if (ARESETn) begin
      if (mAwvalid && mAwready) begin
        checkOutput("awPending", 64'(expAw.size() != 0), 1);
        if (expAw.size() != 0) checkOutput("awBeat", {mAwid, mAwlen, mAwaddr}, expAw.pop_front());
      end
      if (mWvalid && mWready) begin
        checkOutput("wPending", 64'(expW.size() != 0), 1);
        if (expW.size() != 0) checkOutput("wBeat", {mWstrb, mWlast, mWdata}, expW.pop_front());
      end
    end
  end

  task automatic startAw(input int r, input logic [7:0] id, input logic [7:0] len, input logic [31:0] addr);
    sAwid[r*8 +: 8]     = id;
    sAwaddr[r*32 +: 32] = addr;
    sAwlen[r*8 +: 8]    = len;
    sAwsize[r*3 +: 3]   = 3'd2;
    sAwburst[r*2 +: 2]  = BURST_INCR;
    sAwvalid[r]         = 1'b1;
  endtask

  task automatic expectAw(input int r, input logic [7:0] id, input logic [7:0] len, input logic [31:0] addr);
    logic [1:0] idx;
    idx = 2'(r);
    expAw.push_back({idx, id[5:0], len, addr});
  endtask

  task automatic startW(input int r, input int len, input logic [DW-1:0] base);
    sWdata[r*DW +: DW] = base;
    sWstrb[r*SW +: SW] = SW'(r + 1);
    sWlast[r]          = (len == 0);
    sWvalid[r]         = 1'b1;
    wRemain[r]         = len + 1;
  endtask

  task automatic expectW(input int r, input int len, input logic [DW-1:0] base);
    for (int b = 0; b <= len; b++)
      expW.push_back({SW'(r + 1), (b == len), base + DW'(b)});
  endtask

  task automatic applyStimulus();
    logic [NREQ-1:0] hsAw, hsW;
    logic            bHs, awHs;
    logic [7:0]      awId;
    @(negedge ACLK);
    hsAw = sAwvalid & sAwready;
    hsW  = sWvalid & sWready;
    bHs  = mBvalid & mBready;
    awHs = mAwvalid & mAwready;
    awId = mAwid;
    if (guardReq >= 0) begin
      checkOutput("wreadyHeld", 64'(sWready[guardReq]), 0);
      if (hsW[guardUntil] && sWlast[guardUntil]) guardReq = -1;
    end
    @(posedge ACLK);
    #1;
    for (int r = 0; r < NREQ; r++) begin
      if (hsAw[r]) sAwvalid[r] = 1'b0;
      if (hsW[r]) begin
        wRemain[r]--;
        if (wRemain[r] == 0) sWvalid[r] = 1'b0;
        else begin
          sWdata[r*DW +: DW] = sWdata[r*DW +: DW] + 32'd1;
          sWlast[r]          = (wRemain[r] == 1);
        end
      end
    end
    if (autoB) begin
      if (bHs) void'(pendB.pop_front());
      if (awHs) pendB.push_back(awId);
      mBvalid = (pendB.size() != 0);
      if (pendB.size() != 0) mBid = pendB[0];
    end
  endtask

  task automatic runUntilDrained(input string name, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (expAw.size() == 0 && expW.size() == 0 && pendB.size() == 0 && !mBvalid) break;
      applyStimulus();
    end
    checkOutput(name, 64'(expAw.size() + expW.size() + pendB.size()), 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{8'h40, RESP_SLVERR, 1'b1, 4'b0010, 4'b0010, 8'h00, 1'b1};
    vecs[1] = '{8'h40, RESP_OKAY,   1'b1, 4'b0000, 4'b0010, 8'h00, 1'b0};
    vecs[2] = '{8'hC5, RESP_EXOKAY, 1'b1, 4'b1000, 4'b1000, 8'h05, 1'b1};
    vecs[3] = '{8'h3F, RESP_DECERR, 1'b0, 4'b0001, 4'b0000, 8'h3F, 1'b1};
    vecs[4] = '{8'h8A, RESP_OKAY,   1'b1, 4'b1011, 4'b0100, 8'h0A, 1'b0};

    ARESETn  = 1'b0;
    sAwid = '0; sAwaddr = '0; sAwlen = '0; sAwsize = '0; sAwburst = '0; sAwvalid = '0;
    sWdata = '0; sWstrb = '0; sWlast = '0; sWvalid = '0; sBready = '1;
    mAwready = 1'b1; mWready = 1'b1; mBid = '0; mBresp = '0; mBvalid = 1'b0;
    mBid3 = '0; mBvalid3 = 1'b0;
    for (int r = 0; r < NREQ; r++) wRemain[r] = 0;

    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    checkOutput("rstAwvalid", 64'(mAwvalid), 0);
    checkOutput("rstWvalid", 64'(mWvalid), 0);
    checkOutput("rstAwready", 64'(sAwready), 0);
    checkOutput("rstWready", 64'(sWready), 0);
    checkOutput("rstBvalid", 64'(sBvalid), 0);
    checkOutput("rstErrBid", 64'(errBid), 0);
    @(posedge ACLK);
    #1 ARESETn = 1'b1;

    // B routing table, applied between edges so no handshake is taken.
    @(posedge ACLK);
    #1;
    for (int v = 0; v < 5; v++) begin
      mBid = vecs[v].bid; mBresp = vecs[v].resp; mBvalid = vecs[v].bvalid; sBready = vecs[v].bready;
      #1;
      checkOutput($sformatf("bvec%0d.bvalid", v), 64'(sBvalid), 64'(vecs[v].expBvalid));
      checkOutput($sformatf("bvec%0d.bid", v), 64'(sBid), 64'(vecs[v].expBid));
      checkOutput($sformatf("bvec%0d.bresp", v), 64'(sBresp), 64'(vecs[v].resp));
      checkOutput($sformatf("bvec%0d.mbready", v), 64'(mBready), 64'(vecs[v].expMBready));
    end
    mBvalid = 1'b0; mBid = '0; sBready = '1;

    mBid3 = 8'hC0; mBvalid3 = 1'b1;
    #1;
    checkOutput("n3.mBready", 64'(mBready3), 1);
    checkOutput("n3.sBvalid", 64'(sBvalid3), 0);
    checkOutput("n3.errBefore", 64'(errBid3), 0);
    @(posedge ACLK);
    #1 mBvalid3 = 1'b0;
    checkOutput("n3.errSet", 64'(errBid3), 1);
    @(posedge ACLK);
    #1;
    checkOutput("n3.errSticky", 64'(errBid3), 1);
    checkOutput("n4.errClear", 64'(errBid), 0);

    $display("[TB] all four requesters at once");
    autoB = 1'b1;
    for (int r = 0; r < NREQ; r++) begin
      startAw(r, 8'(5 + r), 8'd0, 32'h1000 * r);
      startW(r, 0, 32'hA0 + r);
    end
    for (int r = 0; r < NREQ; r++) begin
      expectAw(r, 8'(5 + r), 8'd0, 32'h1000 * r);
      expectW(r, 0, 32'hA0 + r);
    end
    runUntilDrained("t1.drain", 60);

    $display("[TB] W order follows AW order");
    startAw(2, 8'h12, 8'd3, 32'h2200);
    expectAw(2, 8'h12, 8'd3, 32'h2200);
    startW(0, 1, 32'hB0);
    guardReq = 0; guardUntil = 2;
    for (int c = 0; c < 20 && sAwvalid[2]; c++) applyStimulus();
    startAw(0, 8'h20, 8'd1, 32'h0200);
    expectAw(0, 8'h20, 8'd1, 32'h0200);
    startW(2, 3, 32'hC0);
    expectW(2, 3, 32'hC0);
    expectW(0, 1, 32'hB0);
    runUntilDrained("t2.drain", 60);
    checkOutput("t2.guardReleased", 64'(guardReq), 64'hFFFF_FFFF_FFFF_FFFF);

    $display("[TB] outstanding limit");
    autoB = 1'b0;
    for (int r = 1; r < NREQ; r++) begin
      startAw(r, 8'(r), 8'd0, 32'h3000 + r);
      startW(r, 0, 32'hD0 + r);
      expectAw(r, 8'(r), 8'd0, 32'h3000 + r);
      expectW(r, 0, 32'hD0 + r);
    end
    for (int c = 0; c < 20 && expAw.size() > 1; c++) applyStimulus();
    for (int c = 0; c < 5; c++) begin
      applyStimulus();
      checkOutput("t3.blocked", 64'(mAwvalid), 0);
    end
    mBid = 8'h41; mBvalid = 1'b1;
    #1 checkOutput("t3.bRouted", 64'(sBvalid), 4'b0010);
    applyStimulus();
    mBvalid = 1'b0;
    checkOutput("t3.grantNotYet", 64'(mAwvalid), 0);
    applyStimulus();
    checkOutput("t3.grantAfterB", 64'(mAwvalid), 1);
    runUntilDrained("t3.drain", 30);
    mBid = 8'h82; mBvalid = 1'b1;
    applyStimulus();
    mBid = 8'hC3;
    applyStimulus();
    mBvalid = 1'b0;

    $display("[TB] AWREADY stall");
    autoB = 1'b1;
    mAwready = 1'b0;
    startAw(0, 8'h30, 8'd0, 32'h4000);
    startAw(1, 8'h31, 8'd0, 32'h4100);
    startW(0, 0, 32'hE0);
    startW(1, 0, 32'hE1);
    expectAw(0, 8'h30, 8'd0, 32'h4000);
    expectAw(1, 8'h31, 8'd0, 32'h4100);
    expectW(0, 0, 32'hE0);
    expectW(1, 0, 32'hE1);
    applyStimulus();
    for (int c = 0; c < 5; c++) begin
      checkOutput("t4.awvalid", 64'(mAwvalid), 1);
      checkOutput("t4.awid", 64'(mAwid), 8'h30);
      checkOutput("t4.awaddr", 64'(mAwaddr), 32'h4000);
      checkOutput("t4.awready", 64'(sAwready), 0);
      applyStimulus();
    end
    mAwready = 1'b1;
    #1 checkOutput("t4.awreadyGrant", 64'(sAwready), 4'b0001);
    runUntilDrained("t4.drain", 40);

    $display("[TB] reset mid-burst");
    autoB = 1'b0;
    startAw(1, 8'h11, 8'd3, 32'h5000);
    expectAw(1, 8'h11, 8'd3, 32'h5000);
    startW(1, 3, 32'hF0);
    expectW(1, 3, 32'hF0);
    for (int c = 0; c < 30 && wRemain[1] > 2; c++) applyStimulus();
    checkOutput("t5.midBurst", 64'(wRemain[1]), 2);
    ARESETn = 1'b0;
    #1;
    checkOutput("t5.rstWvalid", 64'(mWvalid), 0);
    checkOutput("t5.rstWready", 64'(sWready), 0);
    @(posedge ACLK);
    #1;
    checkOutput("t5.rstEdgeWvalid", 64'(mWvalid), 0);
    expAw.delete();
    expW.delete();
    ARESETn = 1'b1;
    applyStimulus();
    checkOutput("t5.fifoEmpty", 64'(mWvalid), 0);
    sWvalid[1] = 1'b0;
    wRemain[1] = 0;
    startAw(3, 8'h13, 8'd0, 32'h6300);
    startAw(0, 8'h10, 8'd0, 32'h6000);
    startW(3, 0, 32'h93);
    startW(0, 0, 32'h90);
    expectAw(0, 8'h10, 8'd0, 32'h6000);
    expectAw(3, 8'h13, 8'd0, 32'h6300);
    expectW(0, 0, 32'h90);
    expectW(3, 0, 32'h93);
    runUntilDrained("t5.drain", 40);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
